pif_xi_frontend: RTL and testbench

//  Upstream stage of the PIF control-register block: turns the byte stream from the I2C slave core into
//  the registered XI strobe/address/data bus. It also runs the readback handshake: waits out the fixed
//  XO pipeline latency, holds the read byte for the I2C core, and signals read completion.

---
 rtl/pif_xi_frontend.sv | 173 +++++++++++++++++
 tb/tb_pif_xi_frontend.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pif_xi_frontend.sv
// ---------------------------------------------------------------------------
// pif_xi_frontend
//   Upstream stage of the PIF control-register block. Bytes from the I2C
//   slave core are decoded by their low TYPE_BITS tag into the registered XI
//   address/data/write-strobe bus. A small read FSM waits out the fixed XO
//   pipeline latency, captures the readback byte, holds it for the I2C core
//   and pulses XI_PRdFinished when the byte has been consumed.
//
// Ports
//   xclk            in   system clock
//   sys_rst         in   asynchronous active-low reset
//   byte_stb        in   one-cycle strobe, byte_in valid
//   byte_in[7:0]    in   [TYPE_BITS-1:0] tag, [7:TYPE_BITS] payload
//   rd_req          in   one-cycle strobe, I2C core needs a read byte
//   rd_ack          in   one-cycle strobe, I2C core has shifted out rd_data
//   bus_stop        in   one-cycle strobe, STOP / repeated START seen
//   XO[7:0]         in   readback byte from the control-register block
//   XI_PWr          out  single-cycle write strobe
//   XI_PRWA         out  register address
//   XI_PRdFinished  out  single-cycle pulse, read byte consumed
//   XI_PRdSubA      out  read sub-address counter
//   XI_PD           out  write payload
//   rd_data[7:0]    out  captured XO
//   rd_valid        out  rd_data valid
//   byte_err        out  single-cycle pulse, byte dropped or bad tag
//   dbg_state[1:0]  out  read FSM state (0 IDLE, 1 WAIT, 2 HOLD)
//
// Read handshake: rd_req is accepted only in IDLE. Once rd_valid rises,
// rd_data is frozen and rd_valid stays high until the cycle in which rd_ack
// (or bus_stop) is seen; rd_ack without rd_valid is ignored. bus_stop aborts
// an outstanding read without signalling completion.
// ---------------------------------------------------------------------------
module pif_xi_frontend #(
  parameter int TYPE_BITS  = 2,
  parameter int ADDR_W     = 4,
  parameter int SUBA_W     = 4,
  parameter int RD_LATENCY = 5
) (
  input  logic                xclk,
  input  logic                sys_rst,
  input  logic                byte_stb,
  input  logic [7:0]          byte_in,
  input  logic                rd_req,
  input  logic                rd_ack,
  input  logic                bus_stop,
  input  logic [7:0]          XO,
  output logic                XI_PWr,
  output logic [ADDR_W-1:0]   XI_PRWA,
  output logic                XI_PRdFinished,
  output logic [SUBA_W-1:0]   XI_PRdSubA,
  output logic [7-TYPE_BITS:0] XI_PD,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                byte_err,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // The counter is loaded with RD_LATENCY-1 and XO is captured on the edge
  // where it reads zero, so XO is sampled exactly RD_LATENCY edges after
  // the edge that accepted rd_req.
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LATENCY - 1);

  localparam logic [TYPE_BITS-1:0] TAG_ADDR = TYPE_BITS'(0);
  localparam logic [TYPE_BITS-1:0] TAG_DATA = TYPE_BITS'(1);

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_pwr;
  logic [ADDR_W-1:0]    r_prwa;
  logic                 r_fin;
  logic [SUBA_W-1:0]    r_suba;
  logic [7-TYPE_BITS:0] r_pd;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_err;

  logic                  w_idle;
  logic [TYPE_BITS-1:0]  w_tag;
  logic [ADDR_W-1:0]     w_addr;
  logic [7-TYPE_BITS:0]  w_pay;

  assign w_idle = (r_state == S_IDLE);
  assign w_tag  = byte_in[TYPE_BITS-1:0];
  assign w_addr = byte_in[TYPE_BITS+ADDR_W-1:TYPE_BITS];
  assign w_pay  = byte_in[7:TYPE_BITS];

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pwr   <= 1'b0;
      r_prwa  <= '0;
      r_fin   <= 1'b0;
      r_suba  <= '0;
      r_pd    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_pwr <= 1'b0;
      r_fin <= 1'b0;
      r_err <= 1'b0;

      // Byte decode. Bytes are only accepted while no read is in flight.
      if (byte_stb) begin
        if (!w_idle) begin
          r_err <= 1'b1;
        end else if (w_tag == TAG_ADDR) begin
          r_prwa <= w_addr;
          r_suba <= '0;
        end else if (w_tag == TAG_DATA) begin
          r_pd  <= w_pay;
          r_pwr <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end

      // Read FSM. The sub-address reset above (IDLE only) and the increment
      // below (HOLD only) can never happen on the same edge.
      case (r_state)
        S_IDLE: begin
          if (rd_req) begin
            r_state <= S_WAIT;
            r_cnt   <= LAT_LOAD;
          end
        end
        S_WAIT: begin
          if (bus_stop) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_data  <= XO;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (bus_stop) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end else if (rd_ack) begin
            r_valid <= 1'b0;
            r_fin   <= 1'b1;
            r_suba  <= r_suba + SUBA_W'(1);
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign XI_PWr         = r_pwr;
  assign XI_PRWA        = r_prwa;
  assign XI_PRdFinished = r_fin;
  assign XI_PRdSubA     = r_suba;
  assign XI_PD          = r_pd;
  assign rd_data        = r_data;
  assign rd_valid       = r_valid;
  assign byte_err       = r_err;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_pif_xi_frontend.sv
// ---------------------------------------------------------------------------
// tb_pif_xi_frontend
//   Drives pif_xi_frontend with a table of tagged bytes, directed multi-cycle
//   read/abort/reset sequences and a randomized operation mix. Expected
//   values come from a transaction-level model: current address, payload and
//   sub-address as integers, plus a queue of read bytes awaiting rd_ack.
// ---------------------------------------------------------------------------
module tb_pif_xi_frontend;

  localparam int LAT  = 5;
  localparam int NVEC = 8;

  // ---------------- clock / reset ----------------
  logic       xclk = 1'b0;
  logic       sys_rst;
  logic       byte_stb;
  logic [7:0] byte_in;
  logic       rd_req;
  logic       rd_ack;
  logic       bus_stop;
  logic [7:0] XO;
  logic       XI_PWr;
  logic [3:0] XI_PRWA;
  logic       XI_PRdFinished;
  logic [3:0] XI_PRdSubA;
  logic [5:0] XI_PD;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       byte_err;
  logic [1:0] dbg_state;

  always #5 xclk = ~xclk;

  pif_xi_frontend #(
    .TYPE_BITS(2), .ADDR_W(4), .SUBA_W(4), .RD_LATENCY(LAT)
  ) dut (
    .xclk(xclk), .sys_rst(sys_rst), .byte_stb(byte_stb), .byte_in(byte_in),
    .rd_req(rd_req), .rd_ack(rd_ack), .bus_stop(bus_stop), .XO(XO),
    .XI_PWr(XI_PWr), .XI_PRWA(XI_PRWA), .XI_PRdFinished(XI_PRdFinished),
    .XI_PRdSubA(XI_PRdSubA), .XI_PD(XI_PD), .rd_data(rd_data),
    .rd_valid(rd_valid), .byte_err(byte_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  int m_addr, m_pd, m_suba;

  typedef struct {
    logic [7:0] b;
    logic [3:0] prwa;
    logic [5:0] pd;
    logic       pwr;
    logic       err;
  } vec_t;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level meaning of a byte: tag = b mod 4, payload = b div 4,
  // address = low 4 bits of the payload.
  function automatic int model_byte(input logic [7:0] b);
    int v;
    int tag;
    v   = int'(b);
    tag = v % 4;
    if (tag == 0) begin
      m_addr = (v / 4) % 16;
      m_suba = 0;
    end else if (tag == 1) begin
      m_pd = v / 4;
    end
    return tag;
  endfunction

  task automatic model_reset();
    m_addr = 0;
    m_pd   = 0;
    m_suba = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge xclk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pwr"},   32'(XI_PWr), 0);
    chk({tag, "_prwa"},  32'(XI_PRWA), 0);
    chk({tag, "_fin"},   32'(XI_PRdFinished), 0);
    chk({tag, "_suba"},  32'(XI_PRdSubA), 0);
    chk({tag, "_pd"},    32'(XI_PD), 0);
    chk({tag, "_rdata"}, 32'(rd_data), 0);
    chk({tag, "_valid"}, 32'(rd_valid), 0);
    chk({tag, "_err"},   32'(byte_err), 0);
    chk({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  task automatic chk_xi(input string tag, input int t);
    chk({tag, "_pwr"},  32'(XI_PWr), 32'(t == 1));
    chk({tag, "_err"},  32'(byte_err), 32'(t >= 2));
    chk({tag, "_prwa"}, 32'(XI_PRWA), m_addr);
    chk({tag, "_pd"},   32'(XI_PD), m_pd);
    chk({tag, "_suba"}, 32'(XI_PRdSubA), m_suba);
  endtask

  task automatic send_idle(input logic [7:0] b);
    int t;
    byte_stb = 1'b1;
    byte_in  = b;
    tick();
    byte_stb = 1'b0;
    t = model_byte(b);
    chk_xi("byte", t);
    tick();
    chk("byte_pwr_end", 32'(XI_PWr), 0);
    chk("byte_err_end", 32'(byte_err), 0);
  endtask

  // Launch a read; XO carries `target` only on the cycle it must be sampled.
  task automatic launch_read(input logic [7:0] target, input bit with_byte, input logic [7:0] b);
    int t;
    rd_req = 1'b1;
    if (with_byte) begin
      byte_stb = 1'b1;
      byte_in  = b;
    end
    XO = 8'($urandom);
    tick();
    rd_req   = 1'b0;
    byte_stb = 1'b0;
    if (with_byte) begin
      t = model_byte(b);
      chk_xi("rdbyte", t);
    end
    chk("wait_valid", 32'(rd_valid), 0);
    chk("wait_state", 32'(dbg_state), 1);
    for (int k = 1; k <= LAT; k++) begin
      XO = (k == LAT) ? target : 8'($urandom);
      tick();
      if (k == 1) chk("rdbyte_pwr_end", 32'(XI_PWr), 0);
      if (k < LAT) chk("wait_valid", 32'(rd_valid), 0);
    end
    exp_q.push_back(target);
    chk("valid_rise", 32'(rd_valid), 1);
    chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
    chk("hold_state", 32'(dbg_state), 2);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      XO     = 8'($urandom);
      rd_req = 1'($urandom_range(0, 1));
      tick();
      rd_req = 1'b0;
      chk("hold_valid", 32'(rd_valid), 1);
      chk("hold_data", 32'(rd_data), 32'(exp_q[0]));
      chk("hold_fin", 32'(XI_PRdFinished), 0);
    end
  endtask

  task automatic ack_read();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    void'(exp_q.pop_front());
    m_suba = (m_suba + 1) % 16;
    chk("ack_valid", 32'(rd_valid), 0);
    chk("ack_fin", 32'(XI_PRdFinished), 1);
    chk("ack_suba", 32'(XI_PRdSubA), m_suba);
    chk("ack_state", 32'(dbg_state), 0);
    tick();
    chk("ack_fin_end", 32'(XI_PRdFinished), 0);
  endtask

  task automatic stop_in_wait();
    int n;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    n = $urandom_range(0, LAT - 1);
    for (int i = 0; i < n; i++) tick();
    bus_stop = 1'b1;
    tick();
    bus_stop = 1'b0;
    chk("stopw_valid", 32'(rd_valid), 0);
    chk("stopw_state", 32'(dbg_state), 0);
    chk("stopw_suba", 32'(XI_PRdSubA), m_suba);
    for (int i = 0; i < LAT + 1; i++) begin
      tick();
      chk("stopw_idle_valid", 32'(rd_valid), 0);
      chk("stopw_idle_fin", 32'(XI_PRdFinished), 0);
    end
  endtask

  task automatic stop_in_hold();
    launch_read(8'($urandom), 1'b0, 8'h00);
    hold($urandom_range(0, 2));
    bus_stop = 1'b1;
    rd_ack   = 1'b1;
    tick();
    bus_stop = 1'b0;
    rd_ack   = 1'b0;
    void'(exp_q.pop_front());
    chk("stoph_valid", 32'(rd_valid), 0);
    chk("stoph_fin", 32'(XI_PRdFinished), 0);
    chk("stoph_suba", 32'(XI_PRdSubA), m_suba);
    chk("stoph_state", 32'(dbg_state), 0);
    tick();
    chk("stoph_fin_end", 32'(XI_PRdFinished), 0);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{8'h0C, 4'h3, 6'h00, 1'b0, 1'b0};
    vecs[1] = '{8'h55, 4'h3, 6'h15, 1'b1, 1'b0};
    vecs[2] = '{8'h0F, 4'h3, 6'h15, 1'b0, 1'b1};
    vecs[3] = '{8'hFE, 4'h3, 6'h15, 1'b0, 1'b1};
    vecs[4] = '{8'hF0, 4'hC, 6'h15, 1'b0, 1'b0};
    vecs[5] = '{8'hFD, 4'hC, 6'h3F, 1'b1, 1'b0};
    vecs[6] = '{8'h02, 4'hC, 6'h3F, 1'b0, 1'b1};
    vecs[7] = '{8'hA8, 4'hA, 6'h3F, 1'b0, 1'b0};

    sys_rst  = 1'b0;
    byte_stb = 1'b0;
    byte_in  = 8'h00;
    rd_req   = 1'b0;
    rd_ack   = 1'b0;
    bus_stop = 1'b0;
    XO       = 8'h00;
    model_reset();
    #3;
    chk_all_zero("reset");
    tick();
    tick();
    sys_rst = 1'b1;
    tick();

    // Tag decode table.
    for (int i = 0; i < NVEC; i++) begin
      byte_stb = 1'b1;
      byte_in  = vecs[i].b;
      tick();
      byte_stb = 1'b0;
      void'(model_byte(vecs[i].b));
      chk("tbl_pwr",  32'(XI_PWr),   32'(vecs[i].pwr));
      chk("tbl_err",  32'(byte_err), 32'(vecs[i].err));
      chk("tbl_prwa", 32'(XI_PRWA),  32'(vecs[i].prwa));
      chk("tbl_pd",   32'(XI_PD),    32'(vecs[i].pd));
      tick();
      chk("tbl_pwr_end", 32'(XI_PWr), 0);
      chk("tbl_err_end", 32'(byte_err), 0);
    end

    // Basic read with XO = A5.
    launch_read(8'hA5, 1'b0, 8'h00);
    hold(2);
    ack_read();

    // Spurious rd_ack / bus_stop in IDLE.
    rd_ack   = 1'b1;
    bus_stop = 1'b1;
    tick();
    rd_ack   = 1'b0;
    bus_stop = 1'b0;
    chk("idle_ack_fin", 32'(XI_PRdFinished), 0);
    chk("idle_ack_suba", 32'(XI_PRdSubA), m_suba);
    chk("idle_ack_state", 32'(dbg_state), 0);

    // Sub-address sweep with wrap, then ADDR byte mid-sequence.
    send_idle(8'h14);
    for (int i = 0; i < 16; i++) begin
      launch_read(8'($urandom), 1'b0, 8'h00);
      ack_read();
    end
    chk("wrap_suba", 32'(XI_PRdSubA), 0);
    for (int i = 0; i < 3; i++) begin
      launch_read(8'($urandom), 1'b0, 8'h00);
      ack_read();
    end
    send_idle(8'h24);
    chk("addr_clears_suba", 32'(XI_PRdSubA), 0);

    // Byte and rd_req in the same IDLE cycle.
    launch_read(8'h5A, 1'b1, 8'hC9);
    ack_read();

    // Aborts.
    stop_in_wait();
    stop_in_hold();

    // Byte during HOLD is dropped.
    launch_read(8'h77, 1'b0, 8'h00);
    byte_stb = 1'b1;
    byte_in  = 8'h55;
    tick();
    byte_stb = 1'b0;
    chk("holdbyte_err", 32'(byte_err), 1);
    chk("holdbyte_pwr", 32'(XI_PWr), 0);
    chk("holdbyte_prwa", 32'(XI_PRWA), m_addr);
    chk("holdbyte_pd", 32'(XI_PD), m_pd);
    chk("holdbyte_valid", 32'(rd_valid), 1);
    ack_read();

    // Asynchronous reset during HOLD.
    send_idle(8'h3C);
    launch_read(8'hC3, 1'b0, 8'h00);
    hold(1);
    sys_rst = 1'b0;
    #2;
    chk_all_zero("async_rst");
    sys_rst = 1'b1;
    model_reset();
    tick();
    launch_read(8'h3C, 1'b0, 8'h00);
    ack_read();
    chk("post_rst_suba", 32'(XI_PRdSubA), 1);

    // Randomized operation mix.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0: send_idle({4'($urandom), 2'($urandom), 2'b00});
        1: send_idle({6'($urandom), 2'b01});
        2: send_idle({6'($urandom), 1'b1, 1'($urandom)});
        3: begin
          launch_read(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
          hold($urandom_range(0, 3));
          ack_read();
        end
        4: begin
          if ($urandom_range(0, 1) == 1) stop_in_wait();
          else stop_in_hold();
        end
        default: begin
          tick();
          chk("rand_idle_valid", 32'(rd_valid), 0);
          chk("rand_idle_prwa", 32'(XI_PRWA), m_addr);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Bound on total run time in case the DUT wedges a task.
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
